// File: rtl/hardmatch_dispatch.sv
// Packet-to-result dispatcher: forwards the packet stream to header capture, queues eop tags,
// pairs them with in-order match results and presents {miss_flag, dest, tag} in a show-ahead queue.
module hardmatch_dispatch #(
    parameter int TAG_W      = 8,
    parameter int DEST_W     = 2,
    parameter int TAGQ_DEPTH = 4,
    parameter int OUTQ_DEPTH = 16,
    parameter int MISS_MODE  = 0,
    parameter int MISS_DEST  = 0,
    parameter int CNT_W      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [TAG_W+65:0]         pnode_data,
    input  logic                      pnode_valid,
    output logic                      pnode_ready,
    output logic [63:0]               cap_data,
    output logic                      cap_sop,
    output logic                      cap_eop,
    output logic                      cap_valid,
    input  logic                      cap_ready,
    input  logic                      match_hit,
    input  logic                      match_valid,
    output logic                      match_ready,
    output logic [DEST_W+TAG_W:0]     data_out,
    output logic                      data_valid,
    input  logic                      data_ack,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count,
    output logic [CNT_W-1:0]          stall_count
);
    localparam int TQ_AW = $clog2(TAGQ_DEPTH);
    localparam int OQ_AW = $clog2(OUTQ_DEPTH);
    localparam int OUT_W = 1 + DEST_W + TAG_W;
    localparam logic [DEST_W-1:0] MISS_DEST_V = DEST_W'(MISS_DEST);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on
    // ready, and data_valid/data_ack form a show-ahead pop where the head is visible before the ack.

    logic [TAG_W-1:0] tagq_mem [TAGQ_DEPTH];
    logic [TQ_AW:0]   tq_wr, tq_rd;
    logic [OUT_W-1:0] outq_mem [OUTQ_DEPTH];
    logic [OQ_AW:0]   oq_wr, oq_rd;

    logic             tagq_empty, tagq_full, outq_empty, outq_full;
    logic             blk, tag_push, res_acc, out_push, out_pop;
    logic [TAG_W-1:0] tag_head;
    logic [OUT_W-1:0] out_entry;

    assign tagq_empty = (tq_wr == tq_rd);
    assign tagq_full  = (tq_wr[TQ_AW] != tq_rd[TQ_AW]) && (tq_wr[TQ_AW-1:0] == tq_rd[TQ_AW-1:0]);
    assign outq_empty = (oq_wr == oq_rd);
    assign outq_full  = (oq_wr[OQ_AW] != oq_rd[OQ_AW]) && (oq_wr[OQ_AW-1:0] == oq_rd[OQ_AW-1:0]);

    assign cap_data = pnode_data[63:0];
    assign cap_sop  = pnode_data[65];
    assign cap_eop  = pnode_data[64];

    // Only the eop beat needs a tag slot, so only it stalls on a full tag queue.
    assign blk         = pnode_data[64] && tagq_full;
    assign cap_valid   = pnode_valid && !blk && !reset;
    assign pnode_ready = cap_ready && !blk && !reset;
    assign tag_push    = pnode_valid && pnode_ready && pnode_data[64];

    assign match_ready = !tagq_empty && !outq_full && !reset;
    assign res_acc     = match_valid && match_ready;
    assign tag_head    = tagq_mem[tq_rd[TQ_AW-1:0]];
    assign out_push    = res_acc && (match_hit || (MISS_MODE != 0));
    assign out_entry   = match_hit ? {1'b0, tag_head[TAG_W-1 -: DEST_W], tag_head}
                                   : {1'b1, MISS_DEST_V, tag_head};

    assign data_valid = !outq_empty && !reset;
    assign data_out   = data_valid ? outq_mem[oq_rd[OQ_AW-1:0]] : '0;
    assign out_pop    = data_ack && data_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            tq_wr <= '0;
            tq_rd <= '0;
            oq_wr <= '0;
            oq_rd <= '0;
        end else begin
            if (tag_push) tq_wr <= tq_wr + (TQ_AW+1)'(1);
            if (res_acc)  tq_rd <= tq_rd + (TQ_AW+1)'(1);
            if (out_push) oq_wr <= oq_wr + (OQ_AW+1)'(1);
            if (out_pop)  oq_rd <= oq_rd + (OQ_AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (tag_push) tagq_mem[tq_wr[TQ_AW-1:0]] <= pnode_data[TAG_W+65:66];
        if (out_push) outq_mem[oq_wr[OQ_AW-1:0]] <= out_entry;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            stall_count <= '0;
        end else begin
            if (res_acc && match_hit && (hit_count != '1))
                hit_count <= hit_count + CNT_W'(1);
            if (res_acc && !match_hit && (miss_count != '1))
                miss_count <= miss_count + CNT_W'(1);
            if (pnode_valid && blk && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hardmatch_dispatch.sv
// Randomized bench for hardmatch_dispatch: transaction-level reference model, expected-result
// queue popped by the monitor whenever the DUT shows data, plus directed fill/stall/reset phases.
module tb_hardmatch_dispatch;
    localparam int TAG_W      = 8;
    localparam int DEST_W     = 2;
    localparam int TAGQ_DEPTH = 4;
    localparam int OUTQ_DEPTH = 16;
    localparam int MISS_MODE  = 1;
    localparam int MISS_DEST  = 2;
    localparam int CNT_W      = 32;
    localparam int OUT_W      = 1 + DEST_W + TAG_W;

    logic               clock = 1'b0;
    logic               reset;
    logic [TAG_W+65:0]  pnode_data;
    logic               pnode_valid, pnode_ready;
    logic [63:0]        cap_data;
    logic               cap_sop, cap_eop, cap_valid, cap_ready;
    logic               match_hit, match_valid, match_ready;
    logic [OUT_W-1:0]   data_out;
    logic               data_valid, data_ack;
    logic [CNT_W-1:0]   hit_count, miss_count, stall_count;

    hardmatch_dispatch #(
        .TAG_W(TAG_W), .DEST_W(DEST_W), .TAGQ_DEPTH(TAGQ_DEPTH), .OUTQ_DEPTH(OUTQ_DEPTH),
        .MISS_MODE(MISS_MODE), .MISS_DEST(MISS_DEST), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .pnode_data(pnode_data), .pnode_valid(pnode_valid), .pnode_ready(pnode_ready),
        .cap_data(cap_data), .cap_sop(cap_sop), .cap_eop(cap_eop),
        .cap_valid(cap_valid), .cap_ready(cap_ready),
        .match_hit(match_hit), .match_valid(match_valid), .match_ready(match_ready),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .hit_count(hit_count), .miss_count(miss_count), .stall_count(stall_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int ack_mode = 0;   // 0 low, 1 high, 2 random
    int cap_mode = 1;   // 1 always ready, 2 random

    logic [OUT_W-1:0] exp_q[$];
    logic [TAG_W-1:0] tag_model[$];
    logic [CNT_W-1:0] exp_hit, exp_miss, exp_stall;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // Background drivers change on +2 so the main thread can retarget them on +1.
    always @(posedge clock) begin
        #2;
        data_ack  = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (ack_mode == 1);
        cap_ready = (cap_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // driver tasks
    task automatic send_beat(input logic [TAG_W-1:0] tag, input logic sop, input logic eop);
        logic acc;
        int   n;
        pnode_data  = {tag, sop, eop, {$urandom, $urandom}};
        pnode_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            acc = pnode_ready;
            tick();
            n++;
        end while (!acc && n < 400);
        if (!acc) check("beat_accept_timeout", 0, 1);
        pnode_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [TAG_W-1:0] tag, input int len);
        for (int i = 0; i < len; i++)
            send_beat((i == len - 1) ? tag : TAG_W'($urandom), i == 0, i == len - 1);
    endtask

    task automatic send_result(input logic hit);
        logic acc;
        int   n;
        match_valid = 1'b1;
        match_hit   = hit;
        n = 0;
        do begin
            @(negedge clock);
            acc = match_ready;
            tick();
            n++;
        end while (!acc && n < 400);
        if (!acc) check("result_accept_timeout", 0, 1);
        match_valid = 1'b0;
        match_hit   = 1'b0;
    endtask

    task automatic drain();
        int n;
        ack_mode = 1;
        n = 0;
        while ((exp_q.size() != 0 || tag_model.size() != 0) && n < 500) begin
            if (tag_model.size() != 0) send_result(1'($urandom_range(0, 1)));
            else tick();
            n++;
        end
        check("drain_empty", exp_q.size() + tag_model.size(), 0);
    endtask

    // Expected output word built from the tag by field arithmetic.
    function automatic logic [OUT_W-1:0] expect_entry(input logic [TAG_W-1:0] t, input logic hit);
        int ti;
        ti = int'(t);
        if (hit) return OUT_W'(((ti >> (TAG_W - DEST_W)) << TAG_W) | ti);
        return OUT_W'((1 << (TAG_W + DEST_W)) | (MISS_DEST << TAG_W) | ti);
    endfunction

    // monitor + scoreboard + reference model, sampled mid-cycle
    always @(negedge clock) begin
        logic blk_e, mr_e;
        logic [TAG_W-1:0] t;
        if (reset) begin
            check("rst_pnode_ready", pnode_ready, 0);
            check("rst_cap_valid",   cap_valid,   0);
            check("rst_match_ready", match_ready, 0);
            check("rst_data_valid",  data_valid,  0);
            check("rst_data_out",    data_out,    0);
            exp_q.delete();
            tag_model.delete();
            exp_hit = '0; exp_miss = '0; exp_stall = '0;
        end else begin
            blk_e = pnode_data[64] && (tag_model.size() == TAGQ_DEPTH);
            mr_e  = (tag_model.size() != 0) && (exp_q.size() < OUTQ_DEPTH);
            check("pnode_ready", pnode_ready, cap_ready && !blk_e);
            check("cap_valid",   cap_valid,   pnode_valid && !blk_e);
            check("match_ready", match_ready, mr_e);
            check("hit_count",   hit_count,   exp_hit);
            check("miss_count",  miss_count,  exp_miss);
            check("stall_count", stall_count, exp_stall);
            if (pnode_valid) begin
                check("cap_data", cap_data, pnode_data[63:0]);
                check("cap_sop_eop", {cap_sop, cap_eop}, pnode_data[65:64]);
            end
            if (exp_q.size() == 0) begin
                check("data_valid_empty", data_valid, 0);
                check("data_out_empty",   data_out,   0);
            end else begin
                check("data_valid", data_valid, 1);
                if (data_valid) check("data_out", data_out, exp_q[0]);
                if (data_ack) void'(exp_q.pop_front());
            end
            if (match_valid && mr_e) begin
                t = tag_model.pop_front();
                if (match_hit) begin
                    exp_hit++;
                    exp_q.push_back(expect_entry(t, 1'b1));
                end else begin
                    exp_miss++;
                    if (MISS_MODE != 0) exp_q.push_back(expect_entry(t, 1'b0));
                end
            end
            if (pnode_valid && cap_ready && !blk_e && pnode_data[64])
                tag_model.push_back(pnode_data[TAG_W+65:66]);
            if (pnode_valid && blk_e) exp_stall++;
        end
    end

    initial begin
        pnode_valid = 1'b0;
        pnode_data  = '0;
        match_valid = 1'b0;
        match_hit   = 1'b0;
        data_ack    = 1'b0;
        cap_ready   = 1'b1;
        exp_hit = '0; exp_miss = '0; exp_stall = '0;
        do_reset(3);

        // three known tags, hit/miss/hit
        ack_mode = 2;
        fork
            begin send_pkt(8'h41, 2); send_pkt(8'h82, 1); send_pkt(8'hC3, 3); end
            begin send_result(1'b1); send_result(1'b0); send_result(1'b1); end
        join
        drain();
        check("known_hits", exp_hit, 2);
        check("known_miss", exp_miss, 1);

        // five packets with no results: fifth eop stalls until one result
        fork
            for (int i = 0; i < 5; i++) send_pkt(TAG_W'($urandom), 2);
            begin repeat (25) tick(); send_result(1'b1); end
        join
        check("stalled_cycles_seen", exp_stall > 0, 1);
        drain();

        // fill the output queue past its depth with ack held low, then release one slot
        ack_mode = 0;
        fork
            for (int i = 0; i < OUTQ_DEPTH + 1; i++) send_pkt(TAG_W'($urandom), 1);
            for (int i = 0; i < OUTQ_DEPTH; i++) send_result(1'b1);
        join
        check("outq_full_model", exp_q.size(), OUTQ_DEPTH);
        fork
            send_result(1'b1);
            begin repeat (4) tick(); ack_mode = 1; tick(); ack_mode = 0; end
        join
        repeat (3) tick();
        check("outq_after_one_ack", exp_q.size(), OUTQ_DEPTH);
        drain();

        // reset with tags and results pending, and a packet half sent
        ack_mode = 0;
        fork
            for (int i = 0; i < 5; i++) send_pkt(TAG_W'($urandom), 1);
            for (int i = 0; i < 3; i++) send_result(1'($urandom_range(0, 1)));
        join
        send_beat(TAG_W'($urandom), 1'b1, 1'b0);
        do_reset(2);
        check("post_reset_hits", exp_hit, 0);
        ack_mode = 2;
        fork
            send_pkt(8'h5A, 2);
            send_result(1'b1);
        join
        drain();

        // randomized traffic
        ack_mode = 2;
        cap_mode = 2;
        fork
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_pkt(TAG_W'($urandom), $urandom_range(1, 4));
            end
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                send_result(1'($urandom_range(0, 1)));
            end
        join
        drain();
        cap_mode = 1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0t exp=finished", $time);
        $fatal(1, "global timeout");
    end
endmodule
